// File: rtl/tlb_ptw_if.sv
// tlb_ptw bundles: requester side (translate/respond) and PTE read port.
// Both carry valid/ready style handshakes; modports fix direction per side.
interface tlb_ptw_req_if #(
  parameter int SADDR = 64,
  parameter int SPCID = 12
);
  logic             req_valid;
  logic             req_ready;
  logic [SADDR-1:0] req_va;
  logic [SPCID-1:0] req_pcid;
  logic [SADDR-1:0] root_base;
  logic             flush;
  logic             resp_valid;
  logic [SADDR-1:0] resp_pa;
  logic             resp_fault;

  modport master (
    output req_valid, req_va, req_pcid,
    output root_base, flush,
    input  req_ready, resp_valid,
    input  resp_pa, resp_fault
  );

  modport slave (
    input  req_valid, req_va, req_pcid,
    input  root_base, flush,
    output req_ready, resp_valid,
    output resp_pa, resp_fault
  );
endinterface

interface tlb_ptw_mem_if #(
  parameter int SADDR = 64
);
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic [SADDR-1:0] mem_addr;
  logic             mem_resp_valid;
  logic [63:0]      mem_rdata;

  modport master (
    output mem_req_valid, mem_addr,
    input  mem_req_ready,
    input  mem_resp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr,
    output mem_req_ready,
    output mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/tlb_ptw.sv
// Radix page-table walker, one walk and one PTE read in flight at a time.
// Define TLB_PTW_CACHE_EN for a one-entry last-level table-base cache.
module tlb_ptw #(
  parameter int SADDR  = 64,
  parameter int SPAGE  = 12,
  parameter int SPCID  = 12,
  parameter int LEVELS = 4,
  parameter int IDXW   = 9
) (
  input  logic clk,
  input  logic rst_n,
  tlb_ptw_req_if.slave  req,
  tlb_ptw_mem_if.master mem
);

  localparam int LW = $clog2(LEVELS);
  localparam int PPNW = SADDR - SPAGE;
  localparam logic [LW-1:0] LAST = LW'(LEVELS - 1);
  localparam logic [LW-1:0] PRE  = LW'(LEVELS - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic [LW-1:0]    r_level;
  logic [LW-1:0]    w_level_n;
  logic [SADDR-1:0] r_va;
  logic [SADDR-1:0] w_va_n;
  logic [SADDR-1:0] r_base;
  logic [SADDR-1:0] w_base_n;
  logic [SADDR-1:0] r_pa;
  logic [SADDR-1:0] w_pa_n;
  logic             r_fault;
  logic             w_fault_n;

  logic             w_fault_ev;
  logic             w_fill_ev;
  logic             w_hit;
  logic [SADDR-1:0] w_c_base;

  logic [SADDR-1:0] w_va_sh;
  logic [IDXW-1:0]  w_idx;
  logic [SADDR-1:0] w_addr;
  logic             w_v;
  logic             w_l;
  logic             w_last;
  logic [PPNW-1:0]  w_ppn;

  // index of the current level, counted down from the top VA bits
  always_comb begin
    w_va_sh = r_va >> (SPAGE + IDXW * (LEVELS - 1 - int'(r_level)));
    w_idx   = w_va_sh[IDXW-1:0];
    w_addr  = r_base
            + {{(SADDR-IDXW-3){1'b0}}, w_idx, 3'b000};
  end

  assign w_v    = mem.mem_rdata[0];
  assign w_l    = mem.mem_rdata[1];
  assign w_ppn  = mem.mem_rdata[SADDR-1:SPAGE];
  assign w_last = (r_level == LAST);

  assign req.req_ready  = (r_state == S_IDLE);
  assign req.resp_valid = (r_state == S_DONE);
  assign req.resp_pa    = r_pa;
  assign req.resp_fault = r_fault;

  assign mem.mem_req_valid = (r_state == S_ISSUE);
  assign mem.mem_addr = (r_state == S_ISSUE) ? w_addr : '0;

  always_comb begin
    w_state_n  = r_state;
    w_level_n  = r_level;
    w_va_n     = r_va;
    w_base_n   = r_base;
    w_pa_n     = r_pa;
    w_fault_n  = r_fault;
    w_fault_ev = 1'b0;
    w_fill_ev  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req.req_valid) begin
          w_va_n    = req.req_va;
          w_base_n  = req.root_base;
          w_level_n = '0;
          w_pa_n    = '0;
          w_fault_n = 1'b0;
          w_state_n = S_ISSUE;
          if (w_hit) begin
            w_level_n = LAST;
            w_base_n  = w_c_base;
          end
        end
      end
      S_ISSUE: begin
        if (mem.mem_req_ready)
          w_state_n = S_WAIT;
      end
      S_WAIT: begin
        if (mem.mem_resp_valid) begin
          // leaf must appear exactly at the last level
          if (!w_v || (w_l != w_last)) begin
            w_pa_n     = '0;
            w_fault_n  = 1'b1;
            w_fault_ev = 1'b1;
            w_state_n  = S_DONE;
          end else if (!w_l) begin
            w_base_n  = {w_ppn, {SPAGE{1'b0}}};
            w_level_n = r_level + LW'(1);
            w_fill_ev = (r_level == PRE);
            w_state_n = S_ISSUE;
          end else begin
            w_pa_n    = {w_ppn, r_va[SPAGE-1:0]};
            w_fault_n = 1'b0;
            w_state_n = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_pa_n    = '0;
        w_fault_n = 1'b0;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_level <= '0;
      r_va    <= '0;
      r_base  <= '0;
      r_pa    <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_level <= w_level_n;
      r_va    <= w_va_n;
      r_base  <= w_base_n;
      r_pa    <= w_pa_n;
      r_fault <= w_fault_n;
    end
  end

`ifdef TLB_PTW_CACHE_EN
  localparam int TAGW = SPCID + IDXW * (LEVELS - 1);

  logic             r_c_vld;
  logic             w_c_vld_n;
  logic [TAGW-1:0]  r_c_tag;
  logic [TAGW-1:0]  w_c_tag_n;
  logic [SADDR-1:0] r_c_base;
  logic [SADDR-1:0] w_c_base_n;
  logic [SPCID-1:0] r_pcid;
  logic [SPCID-1:0] w_pcid_n;
  logic [TAGW-1:0]  w_tag_req;
  logic [TAGW-1:0]  w_tag_walk;

  assign w_tag_req = {req.req_pcid,
    req.req_va[SPAGE+IDXW +: IDXW*(LEVELS-1)]};
  assign w_tag_walk = {r_pcid,
    r_va[SPAGE+IDXW +: IDXW*(LEVELS-1)]};

  assign w_hit = r_c_vld && !req.flush
              && (r_c_tag == w_tag_req);
  assign w_c_base = r_c_base;

  always_comb begin
    w_c_vld_n  = r_c_vld;
    w_c_tag_n  = r_c_tag;
    w_c_base_n = r_c_base;
    w_pcid_n   = r_pcid;
    if (r_state == S_IDLE && req.req_valid)
      w_pcid_n = req.req_pcid;
    if (w_fill_ev) begin
      w_c_vld_n  = 1'b1;
      w_c_tag_n  = w_tag_walk;
      w_c_base_n = w_base_n;
    end
    // flush beats a same-cycle fill
    if (w_fault_ev || req.flush)
      w_c_vld_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_c_vld  <= 1'b0;
      r_c_tag  <= '0;
      r_c_base <= '0;
      r_pcid   <= '0;
    end else begin
      r_c_vld  <= w_c_vld_n;
      r_c_tag  <= w_c_tag_n;
      r_c_base <= w_c_base_n;
      r_pcid   <= w_pcid_n;
    end
  end

  logic w_unused;
  assign w_unused = ^{mem.mem_rdata};
`else
  assign w_hit    = 1'b0;
  assign w_c_base = '0;

  logic w_unused;
  assign w_unused = ^{mem.mem_rdata, req.req_pcid,
                      req.flush, w_fault_ev, w_fill_ev};
`endif

endmodule

// File: tb/tb_tlb_ptw.sv
// Scoreboard bench for tlb_ptw: table-backed memory responder,
// expected reads and responses queued at request time, popped on output.
module tb_tlb_ptw;

  localparam logic [63:0] ROOT = 64'h1000_0000;
  localparam logic [63:0] T1   = 64'h2000_0000;
  localparam logic [63:0] T2   = 64'h3000_0000;
  localparam logic [63:0] T3   = 64'h4000_0000;
  localparam logic [63:0] VA   = 64'h0000_7fff_fab0_0abc;

  typedef struct {
    logic [63:0] pa;
    bit          f;
    int          lat;
    int          nr;
  } exp_t;

  logic clk = 0;
  logic rst_n = 0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_resp = 0;
  int   reads = 0;
  int   rd0 = 0;
  int   t_acc = 0;
  int   stall_n = 0;
  int   stall_cnt = 0;
  bit   hold_resp = 0;
  bit   pend = 0;
  logic [63:0] pend_addr;
  string cur_tag = "none";

  logic [63:0] tbl [logic [63:0]];
  logic [63:0] exp_addr [$];
  exp_t        exp_q [$];

  tlb_ptw_req_if #(.SADDR(64), .SPCID(12)) rq ();
  tlb_ptw_mem_if #(.SADDR(64)) mm ();

  tlb_ptw dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rq.slave),
    .mem   (mm.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rd(input logic [63:0] a);
    return tbl.exists(a) ? tbl[a] : 64'h0;
  endfunction

  function automatic logic [63:0] addr_of(input logic [63:0] base,
      input logic [63:0] va, input int l);
    logic [63:0] ix;
    ix = (va >> (12 + 9 * (3 - l))) & 64'h1ff;
    return base + (ix << 3);
  endfunction

  function automatic void push_addrs(input logic [63:0] va,
      input int slvl, input int n);
    logic [63:0] b, a, p;
    int k;
    b = ROOT;
    k = 0;
    for (int l = 0; l < 4; l++) begin
      a = addr_of(b, va, l);
      if (l >= slvl && k < n) begin
        exp_addr.push_back(a);
        k++;
      end
      p = rd(a);
      b = {p[63:12], 12'h0};
    end
  endfunction

  // memory: optional stall before ready, data one cycle after accept
  initial begin
    mm.mem_req_ready  = 0;
    mm.mem_resp_valid = 0;
    mm.mem_rdata      = 0;
    forever begin
      @(negedge clk);
      mm.mem_resp_valid = 0;
      if (pend && !hold_resp) begin
        mm.mem_resp_valid = 1;
        mm.mem_rdata = rd(pend_addr);
        pend = 0;
      end
      if (mm.mem_req_valid && !pend) begin
        if (stall_cnt < stall_n) begin
          mm.mem_req_ready = 0;
          stall_cnt++;
          if (exp_addr.size() > 0)
            chk({cur_tag, "_addr_stall"}, mm.mem_addr, exp_addr[0]);
        end else begin
          mm.mem_req_ready = 1;
          pend = 1;
          pend_addr = mm.mem_addr;
          stall_cnt = 0;
          reads++;
          if (exp_addr.size() > 0)
            chk({cur_tag, "_addr"}, mm.mem_addr, exp_addr.pop_front());
          else
            chk({cur_tag, "_extra_read"}, 1, 0);
        end
      end else begin
        mm.mem_req_ready = 0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rq.resp_valid) begin
        n_resp++;
        if (exp_q.size() == 0) begin
          chk({cur_tag, "_spurious_resp"}, 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk({cur_tag, "_pa"}, rq.resp_pa, e.pa);
          chk({cur_tag, "_fault"}, rq.resp_fault, e.f);
          chk({cur_tag, "_lat"}, cyc + 1 - t_acc, e.lat);
          chk({cur_tag, "_reads"}, reads - rd0, e.nr);
          chk({cur_tag, "_addr_left"}, exp_addr.size(), 0);
        end
      end
    end
  end

  task automatic walk(input string tag, input logic [63:0] va,
      input logic [11:0] pcid, input int slvl, input logic [63:0] epa,
      input bit ef, input int elat, input int enr);
    exp_t e;
    int n0;
    @(negedge clk);
    for (int i = 0; i < 50 && !rq.req_ready; i++) @(negedge clk);
    cur_tag = tag;
    rq.req_va = va;
    rq.req_pcid = pcid;
    rq.root_base = ROOT;
    rq.req_valid = 1;
    t_acc = cyc + 1;
    rd0 = reads;
    e.pa = epa;
    e.f = ef;
    e.lat = elat;
    e.nr = enr;
    exp_q.push_back(e);
    push_addrs(va, slvl, enr);
    n0 = n_resp;
    @(negedge clk);
    rq.req_valid = 0;
    for (int i = 0; i < 200 && n_resp == n0; i++) @(negedge clk);
    if (n_resp == n0) begin
      chk({tag, "_timeout"}, 0, 1);
      exp_q.delete();
      exp_addr.delete();
    end
  endtask

  task automatic do_flush();
    @(negedge clk);
    rq.flush = 1;
    @(negedge clk);
    rq.flush = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    int r0;
    rq.req_valid = 0;
    rq.req_va = 0;
    rq.req_pcid = 0;
    rq.root_base = 0;
    rq.flush = 0;

    tbl[addr_of(ROOT, VA, 0)] = T1 | 64'h1;
    tbl[addr_of(T1, VA, 1)] = T2 | 64'h1;
    tbl[addr_of(T2, VA, 2)] = T3 | 64'h1;
    tbl[addr_of(T3, VA, 3)] = (64'h12345 << 12) | 64'hff3;
    tbl[addr_of(T2, VA ^ (64'h1 << 21), 2)] = (64'h777 << 12) | 64'h3;
    tbl[addr_of(T3, VA ^ (64'h1 << 12), 3)] = 64'h5000_0001;
    tbl[addr_of(T3, VA ^ (64'h2 << 12), 3)] = (64'h55555 << 12) | 64'h3;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", rq.req_ready, 1);
    chk("rst_resp_valid", rq.resp_valid, 0);
    chk("rst_resp_pa", rq.resp_pa, 0);
    chk("rst_resp_fault", rq.resp_fault, 0);
    chk("rst_mem_req_valid", mm.mem_req_valid, 0);
    chk("rst_mem_addr", mm.mem_addr, 0);
    rst_n = 1;

    do_flush();
    walk("basic", VA, 12'h1, 0, 64'h1234_5abc, 0, 9, 4);
    do_flush();
    walk("va_hi_ign", VA | 64'hffff_0000_0000_0000, 12'h1, 0,
         64'h1234_5abc, 0, 9, 4);
    do_flush();
    walk("invalid_l1", VA ^ (64'h1 << 30), 12'h1, 0, 0, 1, 5, 2);
    do_flush();
    walk("leaf_l2", VA ^ (64'h1 << 21), 12'h1, 0, 0, 1, 7, 3);
    do_flush();
    walk("nonleaf_l3", VA ^ (64'h1 << 12), 12'h1, 0, 0, 1, 9, 4);

    do_flush();
    stall_n = 3;
    walk("stall", VA, 12'h1, 0, 64'h1234_5abc, 0, 21, 4);
    stall_n = 0;

    do_flush();
    hold_resp = 1;
    @(negedge clk);
    cur_tag = "rst_walk";
    rq.req_va = VA;
    rq.req_pcid = 12'h1;
    rq.root_base = ROOT;
    rq.req_valid = 1;
    exp_addr.push_back(addr_of(ROOT, VA, 0));
    r0 = reads;
    @(negedge clk);
    rq.req_valid = 0;
    for (int i = 0; i < 50 && reads == r0; i++) @(negedge clk);
    @(negedge clk);
    chk("rst_in_wait", {rq.req_ready, mm.mem_req_valid, rq.resp_valid}, 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("rst_mid_ready", rq.req_ready, 1);
    chk("rst_mid_memreq", mm.mem_req_valid, 0);
    hold_resp = 0;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (rq.resp_valid || mm.mem_req_valid) bad = 1;
    end
    chk("rst_late_resp_dropped", bad, 0);
    walk("after_rst", VA, 12'h1, 0, 64'h1234_5abc, 0, 9, 4);

`ifdef TLB_PTW_CACHE_EN
    do_flush();
    walk("c_fill", VA, 12'h1, 0, 64'h1234_5abc, 0, 9, 4);
    walk("c_hit", VA ^ (64'h2 << 12), 12'h1, 3,
         64'h5555_5abc, 0, 3, 1);
    walk("c_pcid", VA ^ (64'h2 << 12), 12'h2, 0,
         64'h5555_5abc, 0, 9, 4);
    walk("c_hit2", VA ^ (64'h2 << 12), 12'h2, 3,
         64'h5555_5abc, 0, 3, 1);
    walk("c_hit_fault", VA ^ (64'h1 << 12), 12'h2, 3, 0, 1, 3, 1);
    walk("c_after_fault", VA ^ (64'h2 << 12), 12'h2, 0,
         64'h5555_5abc, 0, 9, 4);
    do_flush();
    walk("c_after_flush", VA ^ (64'h2 << 12), 12'h2, 0,
         64'h5555_5abc, 0, 9, 4);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tlb_ptw.md
# tlb_ptw

Hardware page-table walker serving as the miss responder for the set-associative TLB. It accepts one translation request (VA + PCID) at a time and walks a radix page table of `LEVELS` levels through a single-outstanding memory read port. It returns either the physical address or a fault. The TLB fills its PLRU victim way from the response.

## Interface

**Parameters**
- `SADDR`, default 64: virtual/physical address width.
- `SPAGE`, default 12: page-offset width.
- `SPCID`, default 12: PCID width.
- `LEVELS`, default 4: number of page-table levels (at least 2).
- `IDXW`, default 9: VA index bits per level. PTEs are 64-bit (8 bytes).

**Ports**
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: translation request.
- `req_ready` out 1: high only in IDLE.
- `req_va` in SADDR: VA to translate.
- `req_pcid` in SPCID: requester PCID.
- `root_base` in SADDR: level-0 table base, sampled on request accept.
- `flush` in 1: invalidate walk cache (see Configuration).
- `resp_valid` out 1: one-cycle result pulse.
- `resp_pa` out SADDR: translated PA; 0 on fault.
- `resp_fault` out 1: walk failed; valid with `resp_valid`.
- `mem_req_valid` out 1: PTE read request.
- `mem_req_ready` in 1: memory accepts read.
- `mem_addr` out SADDR: byte address of PTE.
- `mem_resp_valid` in 1: read data valid.
- `mem_rdata` in 64: PTE.

## Operation

**PTE format**
- bit0 V (valid), bit1 L (leaf), bits[SADDR-1:SPAGE] PPN. Other bits are ignored.

**Index and addressing**
- Index for level l (0 = root) is `req_va[SPAGE+IDXW*(LEVELS-1-l) +: IDXW]`.
- VA bits above `SPAGE+IDXW*LEVELS` are ignored.
- Entry address = table_base + {index, 3'b000}, with SADDR-bit wrap-around (no carry out).

**State machine: IDLE → ISSUE → WAIT → {ISSUE | DONE} → IDLE**
- IDLE: `req_ready`=1. On `req_valid`, latch va, pcid and `root_base`; set level=0; go to ISSUE.
- ISSUE: `mem_req_valid`=1 with stable `mem_addr`. When `mem_req_ready`=1, go to WAIT.
- WAIT: hold until `mem_resp_valid`, then evaluate the PTE:
  - V=0 → fault.
  - L=1 at level < LEVELS-1 → fault (no superpages).
  - L=0 at level LEVELS-1 → fault.
  - L=0 at level < LEVELS-1 → table_base = {PPN, SPAGE'b0}, level+1, go to ISSUE.
  - L=1 at last level → success.
- DONE: `resp_valid`=1 for exactly one cycle, then go to IDLE.
  - Success: `resp_pa` = {PPN, va[SPAGE-1:0]}, `resp_fault`=0.
  - Fault: `resp_pa`=0, `resp_fault`=1.

**Boundary behaviour**
- Only one memory read is outstanding at a time.
- `mem_resp_valid` outside WAIT is ignored.
- `req_valid` while busy is not accepted.
- Reset mid-walk aborts to IDLE; any late memory response is dropped.
- Reset values: `req_ready`=1, `resp_valid`=0, `resp_pa`=0, `resp_fault`=0, `mem_req_valid`=0, `mem_addr`=0, level=0, walk cache invalid.

## Timing

- Request accepted at cycle T (`req_valid && req_ready`). `mem_req_valid` rises at T+1.
- With `mem_req_ready`=1 and data returned one cycle after the accept, each level costs 2 cycles.
- `resp_valid` occurs at T+1+2·LEVELS: T+9 for LEVELS=4.
- Each memory-stall cycle (ready low, or response late) adds one cycle.
- A fault at level l responds at T+3+2·l.
- The next request can be accepted the cycle after `resp_valid`.
- `resp_pa` and `resp_fault` are valid only while `resp_valid`=1.

## Configuration

- `TLB_PTW_CACHE_EN` defined: compiles in a one-entry walk cache.
  - Tag = {pcid, VA index bits of levels 0..LEVELS-2}. Data = last-level table base.
  - Written when the walk reaches level LEVELS-1.
  - On accept with a tag match, the walk starts directly at level LEVELS-1, so `resp_valid` occurs at T+3.
  - A fault at any level, `flush`=1 or reset invalidates the entry.
  - If `flush` and a cache write occur in the same cycle, `flush` wins.
- Undefined: no cache; `flush` is ignored; every walk starts at level 0.

## Test plan

- **Basic walk.** LEVELS=4; zero-wait memory; PTE chain V=1 L=0 ×3, then leaf PPN=0x12345; va=0x0000_7fff_fab0_0abc. Required: four reads at the correct addresses; `resp_valid` at T+9; `resp_pa`=0x12345abc; `resp_fault`=0.
- **Invalid PTE.** Level-1 PTE=0 (V=0). Required: `resp_fault`=1, `resp_pa`=0 at T+5; only two reads issued.
- **Superpage/leaf errors.** Leaf at level 2 → fault at T+7. Non-leaf at level 3 → fault at T+9.
- **Backpressure and reset.** `mem_req_ready` low for 3 cycles per level → response at T+21; `mem_addr` stable while stalled. Separately, assert `rst_n`=0 during WAIT → IDLE next cycle; a later `mem_resp_valid` produces no `resp_valid`.
- **Walk cache (`TLB_PTW_CACHE_EN`).** A second request to the same 2 MB region with the same pcid → one read, `resp_valid` at T+3. A different pcid → full walk at T+9. After `flush` → full walk at T+9.
